// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bundle between the core and the data memory responder
//
// Purpose: groups the load/store request handshake and the response handshake.
// Signals:
//   req_valid/req_ready  request handshake (core -> memory)
//   req_we               1 = store, 0 = load
//   req_addr             word address
//   req_wdata            store data
//   rsp_valid/rsp_ready  response handshake (memory -> core)
//   rsp_rdata            load data, or echo of store data on a write acknowledge
//   rsp_we               1 = response is a write acknowledge
// Modports: master = core side, slave = memory responder side.
interface data_mem_responder_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_we;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_we
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_we
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data RAM behind a valid/ready request/response handshake
//
// Purpose: accepts one load/store at a time, waits LATENCY edges, performs the
// access, then holds the response until the core consumes it.
// Ports:
//   clk           clock, all state changes on the rising edge
//   reset         asynchronous active-high reset (clears state and memory)
//   bus           data_mem_responder_if.slave request/response bundle
//   busy          request accepted and response not yet consumed
//   access_count  completed response handshakes, wraps modulo 256
module data_mem_responder #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter int LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus,
   output logic                 busy,
   output logic [7:0]           access_count
);

   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
         $error("data_mem_responder: LATENCY must be in 1..15");
      end
   endgenerate

   localparam int         DEPTH = 2 ** ADDR_W;
   localparam logic [3:0] LAT   = 4'(LATENCY);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_we;
   logic [DATA_W-1:0] mem [DEPTH];

   // Handshake outputs decode straight from state so reset removes them immediately.
   assign bus.req_ready = (state == S_IDLE);
   assign bus.rsp_valid = (state == S_RESP);
   assign busy          = (state != S_IDLE);
   assign bus.rsp_rdata = rsp_rdata;
   assign bus.rsp_we    = rsp_we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         cnt          <= '0;
         lat_we       <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         rsp_rdata    <= '0;
         rsp_we       <= 1'b0;
         access_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               // Request fields are latched here and never looked at again
               // until the next acceptance.
               if (bus.req_valid) begin
                  lat_we    <= bus.req_we;
                  lat_addr  <= bus.req_addr;
                  lat_wdata <= bus.req_wdata;
                  cnt       <= LAT;
                  state     <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               // The access happens on the last wait edge, so a store is only
               // committed if no reset arrives before it.
               if (cnt == 4'd1) begin
                  if (lat_we) begin
                     mem[lat_addr] <= lat_wdata;
                     rsp_rdata     <= lat_wdata;
                     rsp_we        <= 1'b1;
                  end else begin
                     rsp_rdata <= mem[lat_addr];
                     rsp_we    <= 1'b0;
                  end
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               // Returning to IDLE here (not accepting) enforces the one-cycle
               // gap between a consumed response and the next request.
               if (bus.rsp_ready) begin
                  access_count <= access_count + 8'd1;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic       busy_a, busy_b;
   logic [7:0] cnt_a, cnt_b;

   int checks = 0;
   int errors = 0;

   logic [15:0] mdl_mem [8];
   int          mdl_cnt;
   int          mdl_cnt_b;

   always #5 clk = ~clk;

   data_mem_responder_if #(.DATA_W(16), .ADDR_W(3)) ifa ();
   data_mem_responder_if #(.DATA_W(16), .ADDR_W(3)) ifb ();

   data_mem_responder #(.DATA_W(16), .ADDR_W(3), .LATENCY(2)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa), .busy(busy_a), .access_count(cnt_a)
   );

   data_mem_responder #(.DATA_W(16), .ADDR_W(3), .LATENCY(1)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb), .busy(busy_b), .access_count(cnt_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mdl_mem[i] = 16'h0000;
      mdl_cnt   = 0;
      mdl_cnt_b = 0;
   endtask

   // Issues one request on ifa from IDLE and completes it; returns what was observed.
   // scramble keeps req_valid high and changes req_* while the access is pending.
   task automatic do_txn(input logic we, input logic [2:0] addr, input logic [15:0] wdata,
                         input bit scramble, input int hold,
                         output logic [15:0] rd, output logic rwe, output int lat,
                         output bit stable);
      ifa.req_valid = 1'b1;
      ifa.req_we    = we;
      ifa.req_addr  = addr;
      ifa.req_wdata = wdata;
      tick();
      if (scramble) begin
         ifa.req_we    = 1'b1;
         ifa.req_addr  = 3'd5;
         ifa.req_wdata = 16'h1234;
      end else begin
         ifa.req_valid = 1'b0;
      end
      lat = 0;
      while (ifa.rsp_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      ifa.req_valid = 1'b0;
      rd     = ifa.rsp_rdata;
      rwe    = ifa.rsp_we;
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
         tick();
         if (ifa.rsp_valid !== 1'b1 || ifa.rsp_rdata !== rd || ifa.rsp_we !== rwe ||
             ifa.req_ready !== 1'b0)
            stable = 1'b0;
      end
      ifa.rsp_ready = 1'b1;
      tick();
      ifa.rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] rd;
      logic        rwe;
      int          lat;
      bit          st;
      do_txn(1'b1, 3'd2, 16'hA5A5, 1'b0, 0, rd, rwe, lat, st);
      // start a load and reach RESP, then reset in the middle of the cycle
      ifa.req_valid = 1'b1;
      ifa.req_we    = 1'b0;
      ifa.req_addr  = 3'd2;
      tick();
      ifa.req_valid = 1'b0;
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      checks++;
      if (ifa.rsp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_rsp_valid got %b exp 0", ifa.rsp_valid);
      end
      checks++;
      if (busy_a !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b exp 0", busy_a);
      end
      checks++;
      if (cnt_a !== 8'd0) begin
         errors++; $display("FAIL reset_access_count got %0d exp 0", cnt_a);
      end
      checks++;
      if (ifa.rsp_rdata !== 16'h0000 || ifa.rsp_we !== 1'b0) begin
         errors++; $display("FAIL reset_rsp_data got %h/%b exp 0000/0", ifa.rsp_rdata, ifa.rsp_we);
      end
      #2 reset = 1'b0;
      model_reset();
      tick();
      checks++;
      if (ifa.req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_req_ready got %b exp 1", ifa.req_ready);
      end
      for (int a = 0; a < 8; a++) begin
         do_txn(1'b0, 3'(a), 16'hFFFF, 1'b0, 0, rd, rwe, lat, st);
         mdl_cnt++;
         checks++;
         if (rd !== mdl_mem[a] || rwe !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL reset_load addr %0d got %h/%b lat %0d exp %h/0 lat 2", a, rd, rwe, lat, mdl_mem[a]);
         end
      end
      checks++;
      if (cnt_a !== 8'(mdl_cnt)) begin
         errors++; $display("FAIL reset_count got %0d exp %0d", cnt_a, mdl_cnt);
      end
   endtask

   task automatic test_store_load();
      logic [15:0] rd;
      logic        rwe;
      int          lat;
      bit          st;
      do_txn(1'b1, 3'd3, 16'hBEEF, 1'b0, 0, rd, rwe, lat, st);
      mdl_mem[3] = 16'hBEEF;
      mdl_cnt++;
      checks++;
      if (lat != 2 || rwe !== 1'b1 || rd !== 16'hBEEF) begin
         errors++; $display("FAIL store_ack got %h/%b lat %0d exp beef/1 lat 2", rd, rwe, lat);
      end
      do_txn(1'b0, 3'd3, 16'h0000, 1'b0, 0, rd, rwe, lat, st);
      mdl_cnt++;
      checks++;
      if (rd !== mdl_mem[3] || rwe !== 1'b0) begin
         errors++; $display("FAIL load_after_store got %h/%b exp %h/0", rd, rwe, mdl_mem[3]);
      end
      checks++;
      if (cnt_a !== 8'(mdl_cnt)) begin
         errors++; $display("FAIL store_load_count got %0d exp %0d", cnt_a, mdl_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] rd;
      logic        rwe;
      int          lat;
      bit          st;
      logic [2:0]  a;
      a = 3'($urandom_range(0, 7));
      do_txn(1'b0, a, 16'h0000, 1'b0, 5, rd, rwe, lat, st);
      mdl_cnt++;
      checks++;
      if (st !== 1'b1) begin
         errors++; $display("FAIL backpressure_stable got %b exp 1", st);
      end
      checks++;
      if (rd !== mdl_mem[a]) begin
         errors++; $display("FAIL backpressure_data got %h exp %h", rd, mdl_mem[a]);
      end
      checks++;
      if (cnt_a !== 8'(mdl_cnt) || ifa.req_ready !== 1'b1) begin
         errors++; $display("FAIL backpressure_handshake got cnt %0d ready %b exp cnt %0d ready 1", cnt_a, ifa.req_ready, mdl_cnt);
      end
   endtask

   task automatic test_busy_ignore();
      logic [15:0] rd;
      logic [15:0] d;
      logic        rwe;
      int          lat;
      bit          st;
      bit          quiet;
      d = 16'($urandom);
      do_txn(1'b1, 3'd1, d, 1'b1, 0, rd, rwe, lat, st);
      mdl_mem[1] = d;
      mdl_cnt++;
      checks++;
      if (rd !== d || rwe !== 1'b1 || lat != 2) begin
         errors++; $display("FAIL ignore_orig got %h/%b lat %0d exp %h/1 lat 2", rd, rwe, lat, d);
      end
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (ifa.rsp_valid !== 1'b0 || busy_a !== 1'b0) quiet = 1'b0;
         tick();
      end
      checks++;
      if (quiet !== 1'b1 || cnt_a !== 8'(mdl_cnt)) begin
         errors++; $display("FAIL ignore_second_rsp got quiet %b cnt %0d exp quiet 1 cnt %0d", quiet, cnt_a, mdl_cnt);
      end
      do_txn(1'b0, 3'd5, 16'h0000, 1'b0, 0, rd, rwe, lat, st);
      mdl_cnt++;
      checks++;
      if (rd !== mdl_mem[5]) begin
         errors++; $display("FAIL ignore_mem5 got %h exp %h", rd, mdl_mem[5]);
      end
   endtask

   task automatic test_random();
      logic [15:0] rd;
      logic [15:0] d;
      logic [15:0] exp_d;
      logic        rwe;
      logic        we;
      logic [2:0]  a;
      int          lat;
      bit          st;
      for (int n = 0; n < 30; n++) begin
         we = 1'($urandom);
         a  = 3'($urandom);
         d  = 16'($urandom);
         do_txn(we, a, d, 1'b0, int'($urandom_range(0, 3)), rd, rwe, lat, st);
         if (we) mdl_mem[a] = d;
         exp_d = mdl_mem[a];
         mdl_cnt++;
         checks++;
         if (rd !== exp_d || rwe !== we || lat != 2 || st !== 1'b1) begin
            errors++;
            $display("FAIL random_%0d got %h/%b lat %0d stable %b exp %h/%b lat 2 stable 1", n, rd, rwe, lat, st, exp_d, we);
         end
      end
      checks++;
      if (cnt_a !== 8'(mdl_cnt % 256)) begin
         errors++; $display("FAIL random_count got %0d exp %0d", cnt_a, mdl_cnt % 256);
      end
   endtask

   task automatic test_reset_mid_write();
      logic [15:0] rd;
      logic        rwe;
      int          lat;
      bit          st;
      ifa.req_valid = 1'b1;
      ifa.req_we    = 1'b1;
      ifa.req_addr  = 3'd7;
      ifa.req_wdata = 16'h00FF;
      tick();
      ifa.req_valid = 1'b0;
      #2 reset = 1'b1;
      #3 reset = 1'b0;
      model_reset();
      tick();
      do_txn(1'b0, 3'd7, 16'h0000, 1'b0, 0, rd, rwe, lat, st);
      mdl_cnt++;
      checks++;
      if (rd !== mdl_mem[7]) begin
         errors++; $display("FAIL mid_write_load got %h exp %h", rd, mdl_mem[7]);
      end
      checks++;
      if (cnt_a !== 8'(mdl_cnt)) begin
         errors++; $display("FAIL mid_write_count got %0d exp %0d", cnt_a, mdl_cnt);
      end
   endtask

   task automatic test_wrap();
      int bad_rsp;
      int bad_cnt;
      bad_rsp = 0;
      bad_cnt = 0;
      ifb.rsp_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ifb.req_valid = 1'b1;
         ifb.req_we    = 1'b0;
         ifb.req_addr  = 3'($urandom);
         tick();
         ifb.req_valid = 1'b0;
         tick();
         // one edge after acceptance the response must already be valid
         if (ifb.rsp_valid !== 1'b1 || ifb.rsp_rdata !== 16'h0000 || ifb.rsp_we !== 1'b0)
            bad_rsp++;
         tick();
         mdl_cnt_b = (mdl_cnt_b + 1) % 256;
         if (cnt_b !== 8'(mdl_cnt_b) || ifb.req_ready !== 1'b1) bad_cnt++;
      end
      ifb.rsp_ready = 1'b0;
      checks++;
      if (bad_rsp != 0) begin
         errors++; $display("FAIL wrap_latency1_rsp got %0d bad responses exp 0", bad_rsp);
      end
      checks++;
      if (bad_cnt != 0) begin
         errors++; $display("FAIL wrap_count_track got %0d bad counts exp 0", bad_cnt);
      end
      checks++;
      if (cnt_b !== 8'd0) begin
         errors++; $display("FAIL wrap_final got %0d exp 0", cnt_b);
      end
   endtask

   initial begin
      reset         = 1'b1;
      ifa.req_valid = 1'b0;
      ifa.req_we    = 1'b0;
      ifa.req_addr  = '0;
      ifa.req_wdata = '0;
      ifa.rsp_ready = 1'b0;
      ifb.req_valid = 1'b0;
      ifb.req_we    = 1'b0;
      ifb.req_addr  = '0;
      ifb.req_wdata = '0;
      ifb.rsp_ready = 1'b0;
      model_reset();
      #12 reset = 1'b0;
      tick();
      test_reset();
      test_store_load();
      test_backpressure();
      test_busy_ignore();
      test_random();
      test_reset_mid_write();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the 16-bit RISC core's load/store traffic: a multi-cycle data RAM behind a valid/ready request/response handshake.
- Replaces the single-cycle data memory when wait states are needed, so the core's mem_read/mem_write path can be verified against a slow memory.
- Accepts one request at a time, waits LATENCY cycles, then performs the access and returns read data or a write acknowledge.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 3, word-address width; depth is 2**ADDR_W (8 words).
- LATENCY, 2, clock edges from request acceptance to response valid; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  DATA_W  load data, or echo of store data for a write acknowledge.
- rsp_we  output  1  1 = response is a write acknowledge.
- busy  output  1  request accepted and response not yet consumed.
- access_count  output  8  number of completed response handshakes; wraps modulo 256.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE and all memory words clear to 0.
  - Output values during and after reset: req_ready=1 (after release), rsp_valid=0, rsp_rdata=0, rsp_we=0, busy=0, access_count=0.
- State machine, states IDLE, WAIT and RESP:
  - IDLE: req_ready=1 and busy=0. On the edge where req_valid=1, capture we, addr and wdata, load cnt=LATENCY, and go to WAIT.
  - WAIT: req_ready=0, busy=1, and cnt decrements each edge. On the edge where cnt==1, perform the access:
    - Store: mem[addr]<=wdata, rsp_rdata<=wdata, rsp_we<=1.
    - Load: rsp_rdata<=mem[addr], rsp_we<=0.
    - Go to RESP with rsp_valid=1.
  - RESP: rsp_valid=1, busy=1, req_ready=0. rsp_rdata and rsp_we stay stable until the handshake. On the edge where rsp_ready=1, set rsp_valid=0, increment access_count, and go to IDLE.
- Timing:
  - rsp_valid rises exactly LATENCY edges after the acceptance edge.
  - For LATENCY=1, WAIT lasts one cycle.
- No overlap:
  - A new request cannot be accepted in the same cycle a response is consumed. The minimum request-to-request spacing is LATENCY+2 cycles when rsp_ready is held at 1.
- Request signals are sampled only at acceptance. Changes to req_* during WAIT or RESP have no effect.
- A store is committed to memory at the access edge, not at acceptance. A load issued after a store acknowledge therefore returns the new value.
- Reset mid-operation:
  - Reset during WAIT drops the pending access; a store never commits.
  - Reset during RESP drops the response; access_count is not incremented.
- access_count wraps from 255 to 0 with no flag.
- Address is always in range because depth equals 2**ADDR_W.
- rsp_rdata holds its last value while in IDLE. It is not cleared after a handshake.
- Illegal LATENCY of 0: the elaboration check fails.

Test Plan:
- Reset then idle: assert reset mid-cycle -> rsp_valid=0, busy=0, access_count=0 immediately; after release req_ready=1 and a load of every address returns 0x0000.
- Store then load, LATENCY=2: store addr 3 data 0xBEEF accepted at edge 0 -> rsp_valid=1 after edge 2 with rsp_we=1 and rsp_rdata=0xBEEF. Then a load from addr 3 -> rsp_rdata=0xBEEF, rsp_we=0, and access_count=2.
- Response backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_rdata and req_ready=0 stay stable. Raising rsp_ready -> one handshake, access_count increments by exactly 1, and req_ready=1 on the next cycle.
- Request ignored while busy: during WAIT change req_addr to 5 and req_wdata to 0x1234 with req_valid=1 -> the original access completes, mem[5] is unchanged, and no second response is produced.
- Reset mid-write: store addr 7 data 0x00FF, then assert reset during WAIT -> a subsequent load from addr 7 returns 0x0000 and access_count=1 after that load.
- Counter wrap and LATENCY=1 build: issue 256 back-to-back loads with rsp_ready=1 -> each response arrives 1 edge after acceptance, and access_count reads 0 after the 256th handshake.
